// File: rtl/fp_pkt_pkg.sv
// Shared constants, FSM encoding and error codes for the fingerprint-sensor
// packet receive path.
package fp_pkt_pkg;

  // Packet header bytes
  localparam logic [7:0] HDR_BYTE0 = 8'hEF;
  localparam logic [7:0] HDR_BYTE1 = 8'h01;

  // Factory-default module address
  localparam logic [31:0] DEFAULT_ADDR = 32'hFFFF_FFFF;

  // Packet identifiers
  localparam logic [7:0] PID_COMMAND  = 8'h01;
  localparam logic [7:0] PID_DATA     = 8'h02;
  localparam logic [7:0] PID_ACK      = 8'h07;
  localparam logic [7:0] PID_END_DATA = 8'h08;

  // Receive FSM states
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_HDR2  = 4'd1,
    ST_ADDR  = 4'd2,
    ST_PID   = 4'd3,
    ST_LEN_H = 4'd4,
    ST_LEN_L = 4'd5,
    ST_DATA  = 4'd6,
    ST_SUM_H = 4'd7,
    ST_SUM_L = 4'd8
  } rx_state_e;

  // Error codes reported on o_Err_Code
  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_ADDR    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_CSUM    = 2'd3;

  // Address byte idx (0 = MSB) of a 32-bit address; the address is sent MSB first
  function automatic logic [7:0] addr_byte(input logic [31:0] addr, input logic [1:0] idx);
    logic [31:0] sh;
    sh = addr << {idx, 3'b000};
    return sh[31:24];
  endfunction

endpackage

// File: rtl/fp_payload_buf.sv
// Payload buffer: DEPTH x 8 register file, synchronous write, combinational read.
module fp_payload_buf #(
  parameter int DEPTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];

  // Store one payload byte per accepted DATA strobe
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fp_packet_rx_ctrl.sv
// Packet-level receive controller behind uart_rx: frames EF01 packets, checks
// address, length and checksum, buffers the payload and pulses valid/error.
//
// Handshake: i_Rx_DV is a one-cycle strobe qualifying i_Rx_Byte; there is no
// back-pressure, so every strobe is consumed in the cycle it arrives.
// o_Pkt_Valid / o_Err are one-cycle pulses registered on the clock after the
// triggering strobe. o_Dbg_State exposes the FSM state for checkers.
module fp_packet_rx_ctrl
  import fp_pkt_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          MAX_PAYLOAD  = 32,
  parameter int          TIMEOUT_CLKS = 40 * CLKS_PER_BIT,
  parameter logic [31:0] DEV_ADDR     = DEFAULT_ADDR,
  localparam int AW = $clog2(MAX_PAYLOAD),
  localparam int LW = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_Rx_DV,
  input  logic [7:0]    i_Rx_Byte,
  input  logic [AW-1:0] i_Rd_Addr,
  output logic [7:0]    o_Rd_Data,
  output logic          o_Pkt_Valid,
  output logic [7:0]    o_Pkt_PID,
  output logic [LW-1:0] o_Pkt_Len,
  output logic          o_Err,
  output logic [1:0]    o_Err_Code,
  output logic          o_Busy,
  output logic [3:0]    o_Dbg_State
);

  localparam int          TW       = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  rx_state_e     state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;         // address byte index / payload write index
  logic [LW-1:0] len_q, len_d;         // payload byte count N of current packet
  logic [15:0]   csum_q, csum_d;       // running checksum
  logic [7:0]    sum_hi_q, sum_hi_d;   // received checksum high byte
  logic [7:0]    len_hi_q, len_hi_d;   // received length high byte
  logic [7:0]    cur_pid_q, cur_pid_d; // PID of packet in flight
  logic [7:0]    pkt_pid_q, pkt_pid_d;
  logic [LW-1:0] pkt_len_q, pkt_len_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          buf_wr_en;
  logic [15:0]   len_full;

  assign len_full = {len_hi_q, i_Rx_Byte};

  // Next-state, datapath and pulse generation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    csum_d     = csum_q;
    sum_hi_d   = sum_hi_q;
    len_hi_d   = len_hi_q;
    cur_pid_d  = cur_pid_q;
    pkt_pid_d  = pkt_pid_q;
    pkt_len_d  = pkt_len_q;
    err_code_d = err_code_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    tmo_d      = '0;
    buf_wr_en  = 1'b0;

    // Inter-byte timeout; a strobe arriving on the expiry cycle wins
    if (state_q != ST_IDLE && !i_Rx_DV) begin
      if (tmo_q == TMO_LAST) begin
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
        state_d    = ST_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (i_Rx_DV) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_Rx_Byte == HDR_BYTE0) state_d = ST_HDR2;
        end
        ST_HDR2: begin
          if (i_Rx_Byte == HDR_BYTE1) begin
            state_d = ST_ADDR;
            cnt_d   = '0;
          end else if (i_Rx_Byte != HDR_BYTE0) begin
            state_d = ST_IDLE;
          end
        end
        ST_ADDR: begin
          if (i_Rx_Byte != addr_byte(DEV_ADDR, cnt_q[1:0])) begin
            err_d      = 1'b1;
            err_code_d = ERR_ADDR;
            state_d    = ST_IDLE;
          end else if (cnt_q == LW'(3)) begin
            state_d = ST_PID;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
        ST_PID: begin
          cur_pid_d = i_Rx_Byte;
          csum_d    = 16'(i_Rx_Byte);
          state_d   = ST_LEN_H;
        end
        ST_LEN_H: begin
          len_hi_d = i_Rx_Byte;
          csum_d   = csum_q + 16'(i_Rx_Byte);
          state_d  = ST_LEN_L;
        end
        ST_LEN_L: begin
          csum_d = csum_q + 16'(i_Rx_Byte);
          // LEN covers payload plus the two checksum bytes
          if (len_full < 16'd2 || len_full > 16'(MAX_PAYLOAD + 2)) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d   = LW'(len_full - 16'd2);
            cnt_d   = '0;
            state_d = (len_full == 16'd2) ? ST_SUM_H : ST_DATA;
          end
        end
        ST_DATA: begin
          buf_wr_en = 1'b1;
          csum_d    = csum_q + 16'(i_Rx_Byte);
          if (cnt_q == len_q - LW'(1)) begin
            state_d = ST_SUM_H;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
        ST_SUM_H: begin
          sum_hi_d = i_Rx_Byte;
          state_d  = ST_SUM_L;
        end
        ST_SUM_L: begin
          if ({sum_hi_q, i_Rx_Byte} == csum_q) begin
            valid_d   = 1'b1;
            pkt_pid_d = cur_pid_q;
            pkt_len_d = len_q;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      sum_hi_q   <= '0;
      len_hi_q   <= '0;
      cur_pid_q  <= '0;
      pkt_pid_q  <= '0;
      pkt_len_q  <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      sum_hi_q   <= sum_hi_d;
      len_hi_q   <= len_hi_d;
      cur_pid_q  <= cur_pid_d;
      pkt_pid_q  <= pkt_pid_d;
      pkt_len_q  <= pkt_len_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      tmo_q      <= tmo_d;
    end
  end

  fp_payload_buf #(
    .DEPTH(MAX_PAYLOAD)
  ) u_buf (
    .clk    (i_Clock),
    .wr_en  (buf_wr_en),
    .wr_addr(cnt_q[AW-1:0]),
    .wr_data(i_Rx_Byte),
    .rd_addr(i_Rd_Addr),
    .rd_data(o_Rd_Data)
  );

  assign o_Pkt_Valid = valid_q;
  assign o_Pkt_PID   = pkt_pid_q;
  assign o_Pkt_Len   = pkt_len_q;
  assign o_Err       = err_q;
  assign o_Err_Code  = err_code_q;
  assign o_Busy      = (state_q != ST_IDLE);
  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_fp_packet_rx_ctrl.sv
// Bench for fp_packet_rx_ctrl: directed and randomized byte streams checked
// against a stream-parsing reference model.
module tb_fp_packet_rx_ctrl;

  localparam int MAXP = 32;
  localparam int T    = 40 * 87;
  localparam int K_NONE = 0, K_VALID = 1, K_ERR = 2, K_BOTH = 3;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int         kind;
    logic [1:0] code;
    int         cyc;
    logic       busy;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic       pkt_valid;
  logic [7:0] pkt_pid;
  logic [5:0] pkt_len;
  logic       err;
  logic [1:0] err_code;
  logic       busy;
  logic [3:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] last_pid = 8'h00;
  int         last_len = 0;
  logic [1:0] last_code = 2'd0;
  ev_t        obs_q[$];
  int         dv_cyc_q[$];
  logic [7:0] exp_q[$];

  fp_packet_rx_ctrl #(
    .CLKS_PER_BIT(87),
    .MAX_PAYLOAD (MAXP),
    .TIMEOUT_CLKS(T),
    .DEV_ADDR    (32'hFFFF_FFFF)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .i_Rd_Addr  (rd_addr),
    .o_Rd_Data  (rd_data),
    .o_Pkt_Valid(pkt_valid),
    .o_Pkt_PID  (pkt_pid),
    .o_Pkt_Len  (pkt_len),
    .o_Err      (err),
    .o_Err_Code (err_code),
    .o_Busy     (busy),
    .o_Dbg_State(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pulse seen on the falling edge
  always @(negedge clk) begin
    if (pkt_valid || err) begin
      obs_q.push_back('{kind: (pkt_valid && err) ? K_BOTH : (pkt_valid ? K_VALID : K_ERR),
                        code: err_code, cyc: cyc, busy: busy});
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    rx_dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    last_pid = 8'h00;
    last_len = 0;
    last_code = 2'd0;
  endtask

  // ---------------- reference model ----------------
  // Parses the stream from first principles and returns the first event.
  function automatic void model(input byte_q_t s, output int kind, output int idx,
                                output logic [1:0] code, output logic [7:0] pid,
                                output int n, output byte_q_t pay);
    int i, j;
    bit found;
    logic [31:0] addr;
    logic [15:0] len, sum, rx;
    kind = K_NONE; idx = 0; code = 2'd0; pid = 8'h00; n = 0; pay = {};
    addr = 32'hFFFF_FFFF; i = 0; j = 0; found = 1'b0;
    while (!found && i < s.size()) begin
      if (s[i] != 8'hEF) begin
        i++;
      end else begin
        while (i < s.size() && s[i] == 8'hEF) i++;
        if (i < s.size()) begin
          if (s[i] == 8'h01) begin
            found = 1'b1;
            j = i;
          end
          i++;
        end
      end
    end
    if (!found) return;
    for (int k = 0; k < 4; k++) begin
      if (j + 1 + k >= s.size()) return;
      if (s[j+1+k] != addr[31-8*k -: 8]) begin
        kind = K_ERR; code = 2'd1; idx = j + 1 + k;
        return;
      end
    end
    if (j + 7 >= s.size()) return;
    pid = s[j+5];
    len = {s[j+6], s[j+7]};
    if (len < 16'd2 || int'(len) - 2 > MAXP) begin
      kind = K_ERR; code = 2'd2; idx = j + 7;
      return;
    end
    n = int'(len) - 2;
    if (j + 9 + n >= s.size()) begin
      n = 0;
      return;
    end
    sum = 16'(pid) + 16'(s[j+6]) + 16'(s[j+7]);
    for (int k = 0; k < n; k++) begin
      pay.push_back(s[j+8+k]);
      sum = sum + 16'(s[j+8+k]);
    end
    rx = {s[j+8+n], s[j+9+n]};
    idx = j + 9 + n;
    if (rx == sum) kind = K_VALID;
    else begin
      kind = K_ERR;
      code = 2'd3;
    end
  endfunction

  // ---------------- drivers ----------------
  // Called and returns at #1 after a rising edge. The byte after index long_idx
  // arrives exactly on the timeout expiry cycle.
  task automatic send_stream(input byte_q_t s, input int maxgap, input int long_idx);
    int gap;
    for (int i = 0; i < s.size(); i++) begin
      rx_dv = 1'b1;
      rx_byte = s[i];
      dv_cyc_q.push_back(cyc);
      @(posedge clk);
      #1;
      rx_dv = 1'b0;
      gap = (i == long_idx) ? T - 1 : $urandom_range(0, maxgap);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic build_random(output byte_q_t s);
    int sc, n, bad_k;
    logic [15:0] len, sum;
    logic [7:0] pid, b;
    logic [7:0] pids[4];
    pids[0] = 8'h01; pids[1] = 8'h02; pids[2] = 8'h07; pids[3] = 8'h08;
    s = {};
    sc = $urandom_range(0, 9);
    n = $urandom_range(0, MAXP);
    repeat ($urandom_range(0, 2)) s.push_back(8'($urandom_range(0, 8'hEE)));
    if ($urandom_range(0, 3) == 0) s.push_back(8'hEF);
    s.push_back(8'hEF);
    s.push_back(8'h01);
    bad_k = (sc == 7) ? $urandom_range(0, 3) : 4;
    for (int k = 0; k < 4; k++) begin
      if (k == bad_k) begin
        s.push_back(8'($urandom_range(0, 254)));
        return;
      end
      s.push_back(8'hFF);
    end
    pid = pids[$urandom_range(0, 3)];
    s.push_back(pid);
    len = 16'(n + 2);
    if (sc == 8) begin
      case ($urandom_range(0, 2))
        0: len = 16'd0;
        1: len = 16'd1;
        default: len = 16'($urandom_range(MAXP + 3, 600));
      endcase
    end
    s.push_back(len[15:8]);
    s.push_back(len[7:0]);
    if (sc == 8) return;
    sum = 16'(pid) + 16'(len[15:8]) + 16'(len[7:0]);
    for (int k = 0; k < n; k++) begin
      b = 8'($urandom_range(0, 255));
      s.push_back(b);
      sum = sum + 16'(b);
    end
    if (sc == 9) sum = sum ^ 16'($urandom_range(1, 65535));
    s.push_back(sum[15:8]);
    s.push_back(sum[7:0]);
  endtask

  // Drive one stream and check pulses, timing, sticky outputs and payload
  task automatic run_packet(input string name, input byte_q_t s, input int maxgap, input int long_idx);
    int kind, idx, n, exp_n;
    logic [1:0] code;
    logic [7:0] pid;
    byte_q_t pay;
    model(s, kind, idx, code, pid, n, pay);
    obs_q.delete();
    dv_cyc_q.delete();
    send_stream(s, maxgap, long_idx);
    repeat (4) @(posedge clk);
    #1;
    exp_n = (kind == K_NONE) ? 0 : 1;
    n_cmp++;
    if (obs_q.size() != exp_n) begin
      n_bad++;
      $display("FAIL %s event_count: got %0d expected %0d", name, obs_q.size(), exp_n);
    end
    if (exp_n == 1 && obs_q.size() == 1) begin
      n_cmp++;
      if (obs_q[0].kind != kind) begin
        n_bad++;
        $display("FAIL %s event_kind: got %0d expected %0d", name, obs_q[0].kind, kind);
      end
      n_cmp++;
      if (obs_q[0].cyc != dv_cyc_q[idx] + 1) begin
        n_bad++;
        $display("FAIL %s event_cycle: got %0d expected %0d", name, obs_q[0].cyc, dv_cyc_q[idx] + 1);
      end
      n_cmp++;
      if (obs_q[0].busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s busy_at_event: got %0b expected 0", name, obs_q[0].busy);
      end
    end
    if (kind == K_VALID) begin
      last_pid = pid;
      last_len = n;
    end
    if (kind == K_ERR) last_code = code;
    n_cmp++;
    if (pkt_pid !== last_pid) begin
      n_bad++;
      $display("FAIL %s pkt_pid: got %02h expected %02h", name, pkt_pid, last_pid);
    end
    n_cmp++;
    if (pkt_len !== 6'(last_len)) begin
      n_bad++;
      $display("FAIL %s pkt_len: got %0d expected %0d", name, pkt_len, last_len);
    end
    n_cmp++;
    if (err_code !== last_code) begin
      n_bad++;
      $display("FAIL %s err_code: got %0d expected %0d", name, err_code, last_code);
    end
    if (kind == K_VALID) begin
      exp_q = pay;
      for (int k = 0; k < n; k++) begin
        rd_addr = 5'(k);
        #1;
        n_cmp++;
        if (rd_data !== exp_q[0]) begin
          n_bad++;
          $display("FAIL %s payload[%0d]: got %02h expected %02h", name, k, rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset busy: got %0b expected 0", busy); end
    n_cmp++;
    if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL reset valid: got %0b expected 0", pkt_valid); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset err: got %0b expected 0", err); end
    n_cmp++;
    if (pkt_pid !== 8'h00) begin n_bad++; $display("FAIL reset pid: got %02h expected 00", pkt_pid); end
    n_cmp++;
    if (pkt_len !== 6'd0) begin n_bad++; $display("FAIL reset len: got %0d expected 0", pkt_len); end
    n_cmp++;
    if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset err_code: got %0d expected 0", err_code); end
  endtask

  task automatic test_good_ack();
    byte_q_t s;
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0A};
    run_packet("good_ack", s, 2, -1);
  endtask

  task automatic test_bad_checksum();
    byte_q_t s;
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0B};
    run_packet("bad_csum", s, 2, -1);
  endtask

  task automatic test_resync_addr();
    byte_q_t s;
    s = '{8'h55, 8'hEF, 8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h03,
          8'h00, 8'h00, 8'h0A};
    run_packet("resync", s, 1, -1);
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFE};
    run_packet("bad_addr", s, 1, -1);
  endtask

  task automatic test_bad_length();
    byte_q_t s;
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h23};
    run_packet("len_33", s, 0, -1);
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h01};
    run_packet("len_1", s, 0, -1);
  endtask

  task automatic test_timeout();
    byte_q_t s;
    int last_dv;
    obs_q.delete();
    dv_cyc_q.delete();
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF};
    send_stream(s, 0, -1);
    last_dv = dv_cyc_q[dv_cyc_q.size() - 1];
    for (int w = 0; w < T + 20 && obs_q.size() == 0; w++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_bad++;
      $display("FAIL timeout event_count: got %0d expected 1", obs_q.size());
    end else begin
      n_cmp++;
      if (obs_q[0].kind != K_ERR || obs_q[0].code !== 2'd0) begin
        n_bad++;
        $display("FAIL timeout kind_code: got %0d/%0d expected %0d/0", obs_q[0].kind, obs_q[0].code, K_ERR);
      end
      n_cmp++;
      if (obs_q[0].cyc != last_dv + 1 + T) begin
        n_bad++;
        $display("FAIL timeout cycle: got %0d expected %0d", obs_q[0].cyc, last_dv + 1 + T);
      end
    end
    last_code = 2'd0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout busy: got %0b expected 0", busy); end
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h08, 8'h00, 8'h04, 8'h12, 8'h34, 8'h00, 8'h52};
    run_packet("after_timeout", s, 0, -1);
    // A byte landing on the expiry cycle must be accepted
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h03, 8'hA5, 8'h00, 8'hA9};
    run_packet("dv_at_expiry", s, 0, 5);
  endtask

  task automatic test_back_to_back();
    byte_q_t s;
    logic [15:0] sum;
    logic [7:0] b;
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h22};
    sum = 16'h0002 + 16'h0000 + 16'h0022;
    for (int k = 0; k < MAXP; k++) begin
      b = 8'($urandom_range(0, 255));
      s.push_back(b);
      sum = sum + 16'(b);
    end
    s.push_back(sum[15:8]);
    s.push_back(sum[7:0]);
    run_packet("b2b_full", s, 0, -1);
    // Reset mid-packet: no pulse, outputs return to reset values
    obs_q.delete();
    dv_cyc_q.delete();
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07};
    send_stream(s, 0, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_pid = 8'h00;
    last_len = 0;
    last_code = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL midreset events: got %0d expected 0", obs_q.size()); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset busy: got %0b expected 0", busy); end
    n_cmp++;
    if (pkt_pid !== 8'h00) begin n_bad++; $display("FAIL midreset pid: got %02h expected 00", pkt_pid); end
    s = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h07, 8'h00, 8'h03, 8'h00, 8'h00, 8'h0A};
    run_packet("after_reset", s, 0, -1);
  endtask

  task automatic test_random();
    byte_q_t s;
    for (int i = 0; i < 40; i++) begin
      build_random(s);
      run_packet($sformatf("rand%0d", i), s, 3, -1);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good_ack();
    test_bad_checksum();
    test_resync_addr();
    test_bad_length();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_packet_rx_ctrl.md
Name: fp_packet_rx_ctrl

Overview:
Packet-level receive controller that sits directly behind uart_rx on the fingerprint-sensor link. It consumes the byte/valid pulses, frames sensor packets (header EF01, 4-byte address, PID, 16-bit length, payload, 16-bit checksum) and checks address, length and checksum. It buffers the payload, enforces an inter-byte timeout, and reports one valid or error pulse per packet to the authentication FSM.

Parameters:
CLKS_PER_BIT, 87, UART bit period in clocks; used only to derive the default timeout.
MAX_PAYLOAD, 32, payload buffer depth in bytes.
TIMEOUT_CLKS, 40*CLKS_PER_BIT, max clocks between bytes inside a packet.
DEV_ADDR, 32'hFFFFFFFF, expected module address.

Ports:
i_Clock  in  1  system clock
i_Reset  in  1  synchronous, active-high reset
i_Rx_DV  in  1  one-cycle byte strobe from uart_rx
i_Rx_Byte  in  8  received byte, valid with i_Rx_DV
i_Rd_Addr  in  clog2(MAX_PAYLOAD)  payload read index
o_Rd_Data  out  8  payload byte at i_Rd_Addr (combinational read)
o_Pkt_Valid  out  1  one-cycle pulse: good packet received
o_Pkt_PID  out  8  PID of last good packet
o_Pkt_Len  out  clog2(MAX_PAYLOAD+1)  payload byte count of last good packet
o_Err  out  1  one-cycle pulse: packet aborted
o_Err_Code  out  2  0 timeout, 1 address mismatch, 2 bad length, 3 checksum
o_Busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, active-high): state IDLE; o_Pkt_Valid, o_Err, o_Busy = 0; o_Pkt_PID = 0; o_Pkt_Len = 0; o_Err_Code = 0; timeout counter = 0. Buffer contents are don't-care.
- States: IDLE, HDR2, ADDR, PID, LEN_H, LEN_L, DATA, SUM_H, SUM_L.
- States advance only on i_Rx_DV. The block must accept a byte on consecutive cycles.
- IDLE: byte EF -> HDR2. Any other byte is ignored silently.
- HDR2: byte 01 -> ADDR, byte count = 0. Byte EF -> stay in HDR2. Any other byte -> IDLE with no error.
- ADDR: 4 bytes, MSB first, compared with DEV_ADDR. First mismatching byte -> o_Err code 1, then IDLE. After the 4th matching byte -> PID.
- PID: latch the PID byte; checksum accumulator = byte.
- LEN_H, LEN_L: form LEN; add both bytes to the checksum.
  - At LEN_L, payload count N = LEN-2.
  - LEN < 2 or N > MAX_PAYLOAD -> o_Err code 2, then IDLE.
  - N == 0 -> SUM_H; otherwise -> DATA.
- DATA: write each byte to buffer[index] and add it to the checksum. After N bytes -> SUM_H.
- SUM_H, SUM_L: assemble the received checksum.
  - Checksum rule: 16-bit sum of PID, LEN_H, LEN_L and all payload bytes, mod 2^16.
  - Match -> o_Pkt_Valid; o_Pkt_PID and o_Pkt_Len update in the same cycle.
  - Mismatch -> o_Err code 3; o_Pkt_PID and o_Pkt_Len are unchanged.
  - Either way, return to IDLE.
- Latency: o_Pkt_Valid / o_Err is asserted on the clock after the i_Rx_DV that triggers it. The pulse is exactly 1 cycle. The FSM is in IDLE in that same cycle.
- o_Err_Code holds its value until the next error.
- Timeout: the counter runs in every non-IDLE state and clears on each i_Rx_DV.
  - Reaching TIMEOUT_CLKS-1 -> o_Err code 0, then IDLE.
  - If i_Rx_DV coincides with expiry, the byte wins and no timeout fires.
- Buffer data is stable from o_Pkt_Valid until the next packet's first DATA byte. The consumer must read before then.
- Reset mid-packet: immediate return to IDLE; no Valid or Err pulse.

Decomposition:
- Package fp_pkt_pkg holds:
  - header constants 8'hEF and 8'h01;
  - default address 32'hFFFFFFFF;
  - PID constants: 01 command, 02 data, 07 ack, 08 end-of-data;
  - FSM state encoding;
  - error code constants.
- One sub-module, fp_payload_buf: MAX_PAYLOAD x 8 register file with a synchronous write port and a combinational read port.

Test Plan:
- Good ack: EF 01 FF FF FF FF 07 00 03 00 00 0A -> o_Pkt_Valid 1 cycle after the last DV; PID = 07; Len = 1; o_Rd_Data[0] = 00; o_Err never asserts.
- Bad checksum: same stream ending 00 0B -> o_Err with code 3; o_Pkt_PID and o_Pkt_Len keep their previous values.
- Resync and address: 55 EF EF 01 FF FF FF FF 07 00 03 00 00 0A -> one Valid. A separate stream EF 01 FF FE ... -> o_Err code 1 on the 4th byte.
- Bad length: LEN 0x0023 (N = 33 > 32) -> o_Err code 2 after LEN_L. LEN 0x0001 -> o_Err code 2.
- Timeout: send EF 01 FF FF, then idle TIMEOUT_CLKS -> o_Err code 0 and o_Busy drops. A good packet immediately afterwards -> Valid.
- Back-to-back DV and reset: DV pulses on consecutive cycles for a full 34-byte packet -> Valid with Len = 32 and all payload bytes correct. A later packet with i_Reset asserted after the PID byte -> IDLE, no pulse; the next good packet is accepted.
